// File: rtl/shift_arb_ctrl_if.sv
// Request/response bundle between two requesters, the shift controller and
// the result consumer. The controller side takes the slave modport.
interface shift_arb_ctrl_if #(
  parameter int N = 3
);
  localparam int W = 2**N;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_num;
  logic [N-1:0] req0_shift;
  logic         req0_dir;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_num;
  logic [N-1:0] req1_shift;
  logic         req1_dir;

  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic         resp_id;

  modport slave (
    input  req0_valid, req0_num, req0_shift, req0_dir,
    output req0_ready,
    input  req1_valid, req1_num, req1_shift, req1_dir,
    output req1_ready,
    output resp_valid, resp_data, resp_id,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_num, req0_shift, req0_dir,
    input  req0_ready,
    output req1_valid, req1_num, req1_shift, req1_dir,
    input  req1_ready,
    input  resp_valid, resp_data, resp_id,
    output resp_ready
  );
endinterface

// File: rtl/shift_arb_ctrl.sv
// Two-requester round-robin front end for a shared logical barrel shifter.
// Stage 1 holds the granted operands, the shifter is combinational from it,
// stage 2 holds the result until the consumer takes it.
module shift_arb_ctrl #(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  shift_arb_ctrl_if.slave  bus,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1,
  output logic             busy
);
  localparam int W = 2**N;

  logic         v1;
  logic [W-1:0] s1_num;
  logic [N-1:0] s1_shift;
  logic         s1_dir;
  logic         s1_id;
  logic         v2;
  logic [W-1:0] s2_data;
  logic         s2_id;
  logic         last_grant;

  logic         s2_free;
  logic         s1_free;
  logic         grant;
  logic         acc0;
  logic         acc1;
  logic         drain;
  logic [W-1:0] shifted;

  // Stage availability and round-robin grant; with a conflict the port that
  // did not win last time gets the slot.
  always_comb begin
    s2_free = !v2 || bus.resp_ready;
    s1_free = !v1 || s2_free;
    if (bus.req0_valid && bus.req1_valid) grant = !last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
    else                                  grant = 1'b0;
  end

  assign bus.req0_ready = !reset && s1_free && !grant;
  assign bus.req1_ready = !reset && s1_free &&  grant;
  assign acc0  = bus.req0_ready && bus.req0_valid;
  assign acc1  = bus.req1_ready && bus.req1_valid;
  assign drain = v2 && bus.resp_ready;

  // Shared shifter, logical and zero-filled in both directions.
  always_comb begin
    shifted = s1_dir ? (s1_num << s1_shift) : (s1_num >> s1_shift);
  end

  assign bus.resp_valid = v2;
  assign bus.resp_data  = s2_data;
  assign bus.resp_id    = s2_id;
  assign busy           = v1 || v2;

  // Pipeline registers, grant history and completion counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1         <= 1'b0;
      s1_num     <= '0;
      s1_shift   <= '0;
      s1_dir     <= 1'b0;
      s1_id      <= 1'b0;
      v2         <= 1'b0;
      s2_data    <= '0;
      s2_id      <= 1'b0;
      last_grant <= 1'b1;
      done_cnt0  <= '0;
      done_cnt1  <= '0;
    end else begin
      // A refill takes priority over a drain so back-to-back results leave no bubble.
      if (v1 && s2_free) begin
        v2      <= 1'b1;
        s2_data <= shifted;
        s2_id   <= s1_id;
      end else if (drain) begin
        v2 <= 1'b0;
      end

      if (acc0 || acc1) begin
        v1         <= 1'b1;
        s1_num     <= acc1 ? bus.req1_num   : bus.req0_num;
        s1_shift   <= acc1 ? bus.req1_shift : bus.req0_shift;
        s1_dir     <= acc1 ? bus.req1_dir   : bus.req0_dir;
        s1_id      <= acc1;
        last_grant <= acc1;
      end else if (s1_free) begin
        v1 <= 1'b0;
      end

      if (drain && !s2_id) done_cnt0 <= done_cnt0 + CNT_W'(1);
      if (drain &&  s2_id) done_cnt1 <= done_cnt1 + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_shift_arb_ctrl.sv
module tb_shift_arb_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cnt0_a, cnt1_a, cnt0_b, cnt1_b;
  logic [1:0] c0b, c1b;
  logic       busy_a, busy_b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  shift_arb_ctrl_if #(.N(3)) bus();
  shift_arb_ctrl_if #(.N(3)) bus2();

  shift_arb_ctrl #(.N(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .done_cnt0(cnt0_a), .done_cnt1(cnt1_a), .busy(busy_a)
  );

  shift_arb_ctrl #(.N(3), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .done_cnt0(c0b), .done_cnt1(c1b), .busy(busy_b)
  );

  assign cnt0_b = {6'd0, c0b};
  assign cnt1_b = {6'd0, c1b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated request on a port, followed through to its handshake.
  task automatic single(input bit port, input logic [7:0] num, input logic [2:0] sh,
                        input bit dir, input logic [7:0] exp, input int c0, input int c1,
                        input string tag);
    if (port) begin
      bus.req1_num = num; bus.req1_shift = sh; bus.req1_dir = dir; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_num = num; bus.req0_shift = sh; bus.req0_dir = dir; bus.req0_valid = 1'b1;
    end
    #1;
    chk({tag, "_ready"}, port ? bus.req1_ready : bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk({tag, "_lat1_valid"}, bus.resp_valid, 0);
    tick();
    chk({tag, "_valid"}, bus.resp_valid, 1);
    chk({tag, "_data"}, bus.resp_data, exp);
    chk({tag, "_id"}, bus.resp_id, port);
    tick();
    chk({tag, "_cnt0"}, cnt0_a, c0);
    chk({tag, "_cnt1"}, cnt1_a, c1);
    chk({tag, "_idle"}, busy_a, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_num = '0; bus.req0_shift = '0; bus.req0_dir = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_num = '0; bus.req1_shift = '0; bus.req1_dir = 1'b0;
    bus.resp_ready = 1'b1;
    bus2.req0_valid = 1'b0; bus2.req0_num = '0; bus2.req0_shift = '0; bus2.req0_dir = 1'b0;
    bus2.req1_valid = 1'b0; bus2.req1_num = '0; bus2.req1_shift = '0; bus2.req1_dir = 1'b0;
    bus2.resp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_cnt0", cnt0_a, 0);
    chk("rst_cnt1", cnt1_a, 0);
    chk("rst_busy", busy_a, 0);
    bus.req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Single operations, two-cycle latency
    single(1'b0, 8'h96, 3'd3, 1'b0, 8'h12, 1, 0, "rshift3");
    single(1'b0, 8'h96, 3'd3, 1'b1, 8'hB0, 2, 0, "lshift3");
    single(1'b0, 8'h96, 3'd0, 1'b0, 8'h96, 3, 0, "shift0");
    single(1'b0, 8'h01, 3'd7, 1'b1, 8'h80, 4, 0, "lshift7");
    single(1'b1, 8'h80, 3'd7, 1'b0, 8'h01, 4, 1, "p1_rshift7");
    single(1'b1, 8'hFF, 3'd4, 1'b0, 8'h0F, 4, 2, "p1_rshift4");

    // Both ports continuously valid: strict alternation starting at port 0
    bus.req0_num = 8'h0F; bus.req0_shift = 3'd1; bus.req0_dir = 1'b1;
    bus.req1_num = 8'hF0; bus.req1_shift = 3'd2; bus.req1_dir = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_ready0_%0d", i), bus.req0_ready, (i % 2 == 0));
      chk($sformatf("rr_ready1_%0d", i), bus.req1_ready, (i % 2 == 1));
      tick();
      if (i >= 1) begin
        chk($sformatf("rr_valid_%0d", i), bus.resp_valid, 1);
        chk($sformatf("rr_id_%0d", i), bus.resp_id, (i - 1) % 2);
        chk($sformatf("rr_data_%0d", i), bus.resp_data, ((i - 1) % 2 == 1) ? 8'h3C : 8'h1E);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    chk("rr_last_id", bus.resp_id, 1);
    chk("rr_last_data", bus.resp_data, 8'h3C);
    tick();
    chk("rr_cnt0", cnt0_a, 7);
    chk("rr_cnt1", cnt1_a, 5);
    chk("rr_idle", busy_a, 0);

    // Backpressure: two operations fill the pipe, then ready drops
    bus.resp_ready = 1'b0;
    bus.req0_num = 8'h01; bus.req0_shift = 3'd1; bus.req0_dir = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    chk("bp_accept_a", bus.req0_ready, 1);
    tick();
    bus.req0_num = 8'h02;
    #1;
    chk("bp_accept_b", bus.req0_ready, 1);
    tick();
    bus.req0_num = 8'h03;
    #1;
    chk("bp_full_ready", bus.req0_ready, 0);
    chk("bp_full_valid", bus.resp_valid, 1);
    chk("bp_full_data", bus.resp_data, 8'h02);
    tick();
    chk("bp_hold1_ready", bus.req0_ready, 0);
    chk("bp_hold1_data", bus.resp_data, 8'h02);
    chk("bp_hold1_id", bus.resp_id, 0);
    tick();
    chk("bp_hold2_ready", bus.req0_ready, 0);
    chk("bp_hold2_data", bus.resp_data, 8'h02);
    chk("bp_hold2_busy", busy_a, 1);
    chk("bp_hold2_cnt0", cnt0_a, 7);
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    chk("bp_drain_b", bus.resp_data, 8'h04);
    chk("bp_drain_b_valid", bus.resp_valid, 1);
    tick();
    chk("bp_drain_c", bus.resp_data, 8'h06);
    chk("bp_drain_c_valid", bus.resp_valid, 1);
    tick();
    chk("bp_done_valid", bus.resp_valid, 0);
    chk("bp_cnt0", cnt0_a, 10);
    chk("bp_idle", busy_a, 0);

    // Reset with two operations in flight; last winner before reset is port 0
    bus.resp_ready = 1'b0;
    bus.req0_num = 8'h11; bus.req0_shift = 3'd0; bus.req0_dir = 1'b0;
    bus.req0_valid = 1'b1;
    tick();
    tick();
    chk("mid_busy_before", busy_a, 1);
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    #1;
    chk("mid_rst_ready1", bus.req1_ready, 0);
    tick();
    reset = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("mid_resp_valid", bus.resp_valid, 0);
    chk("mid_busy", busy_a, 0);
    chk("mid_cnt0", cnt0_a, 0);
    chk("mid_cnt1", cnt1_a, 0);
    chk("mid_resp_data", bus.resp_data, 0);
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("post_rst_grant0", bus.req0_ready, 1);
    chk("post_rst_grant1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    chk("post_rst_id", bus.resp_id, 0);
    chk("post_rst_data", bus.resp_data, 8'h11);
    tick();
    chk("post_rst_cnt0", cnt0_a, 1);

    // Two-bit counters wrap
    for (int k = 1; k <= 5; k++) begin
      bus2.req1_num = 8'(k);
      bus2.req1_valid = 1'b1;
      #1;
      chk($sformatf("w2_ready_%0d", k), bus2.req1_ready, 1);
      tick();
      bus2.req1_valid = 1'b0;
      tick();
      chk($sformatf("w2_data_%0d", k), bus2.resp_data, k);
      tick();
      chk($sformatf("w2_cnt1_%0d", k), cnt1_b, k % 4);
    end
    chk("w2_cnt0", cnt0_b, 0);
    chk("w2_idle", busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_arb_ctrl.md
# shift_arb_ctrl

Sequencing and arbitration controller that shares one combinational left/right barrel shifter datapath (2**N-bit data, N-bit shift amount, direction select) between two requesters. It registers the granted operands, drives the shifter, registers the result, and returns it with the requester ID over a valid/ready response channel. It is fully pipelined, sustaining one shift per cycle, with backpressure, round-robin fairness and per-requester completion counters. It sits between the client logic and the shared shifter instance.

## Interface
- N, default 3: log2 of data width. Data width W = 2**N; shift amount is N bits.
- CNT_W, default 8: width of each completion counter.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester k has an operation pending.
- req0_ready / req1_ready  out  1  requester k's operation is accepted this cycle.
- req0_num / req1_num  in  W  operand.
- req0_shift / req1_shift  in  N  shift amount, 0..W-1.
- req0_dir / req1_dir  in  1  0 = logical right, 1 = logical left.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  W  shifted result.
- resp_id  out  1  requester that issued the result.
- done_cnt0 / done_cnt1  out  CNT_W  completed-response count per requester.
- busy  out  1  any pipeline stage is occupied.

## Operation
- Shift semantics: right shift and left shift are logical and zero-filled. Shift 0 passes num unchanged. The result is truncated to W bits.
- Pipeline:
  - S1 is the operand register: num, shift, dir, id and v1.
  - S2 is the result register: data, id and v2.
  - The shifter is combinational from S1. resp_valid = v2.
- Stall rules:
  - s2_free = !v2 | resp_ready.
  - s1_free = !v1 | s2_free.
  - S1 advances to S2 when v1 & s2_free.
  - S2 clears when it drains (resp_valid & resp_ready) and S1 does not refill it.
- Arbitration:
  - Round-robin with a last_grant register, reset to 1 so that port 0 wins first.
  - If only one port is valid, that port is granted.
  - If both are valid, the port other than last_grant is granted.
  - last_grant updates only on an accepted request.
- reqk_ready = s1_free & grant==k. At most one ready is high per cycle. Ready may depend combinationally on valid. Requesters must not make valid depend on ready.
- An accepted request loads S1 at the edge.
- Requesters hold valid and all operand fields stable until ready; the block does not sample unaccepted operands.
- Counters:
  - done_cntk increments on each response handshake with resp_id==k.
  - Counters wrap from 2**CNT_W-1 to 0.
- busy = v1 | v2.

## Timing
- Reset values:
  - req0_ready = 0, req1_ready = 0 while reset is high.
  - resp_valid = 0, resp_data = 0, resp_id = 0.
  - done_cnt0 = 0, done_cnt1 = 0, busy = 0.
  - v1 = 0, v2 = 0, last_grant = 1.
- Latency:
  - Request accepted at edge t, with no backpressure.
  - resp_valid is high in the cycle after edge t+1, i.e. 2 cycles.
- Throughput: 1 accept per cycle while resp_ready stays high.
- Backpressure:
  - With resp_ready low, S2 holds and S1 holds if occupied. Ready drops once both stages are full.
  - Holding capacity is at most 2 in-flight operations.
  - resp_data and resp_id stay stable while resp_valid & !resp_ready.
- Simultaneous events:
  - A drain and a refill of S2 in the same cycle keeps v2 = 1 with new data, with no bubble.
  - An accept into S1 while S1 advances is allowed.
- Reset mid-operation: all in-flight operations are discarded and counters clear. resp_valid is 0 in the cycle after the reset edge, and no partial response is emitted.
- Ordering: responses return in acceptance order.

## Test plan
- N=3, one request: port0 num=0x96, shift=3, dir=0. Response at 2-cycle latency: resp_data=0x12, resp_id=0, done_cnt0=1.
- Same operand with dir=1 -> resp_data=0xB0. shift=0 -> 0x96. Shift 7 left of 0x01 -> 0x80.
- Both ports held valid for 6 cycles with resp_ready=1:
  - Grants alternate 0,1,0,1,0,1, starting with port 0.
  - One accept per cycle.
  - done_cnt0=3, done_cnt1=3.
- Backpressure:
  - Hold resp_ready=0 with port0 streaming. Exactly 2 requests are accepted, then ready=0, and resp_data stays stable.
  - Release resp_ready. Results drain in order with no loss or duplication.
- Assert reset with 2 operations in flight. Next cycle: resp_valid=0, busy=0, counters=0. The first post-reset conflict is granted to port 0.
- CNT_W=2: 5 port1 responses -> done_cnt1 sequence 1,2,3,0,1. done_cnt0 remains 0.
